// File: rtl/alu_seq_pkg.sv
// Shared op codes, flag indices and FSM encoding for the ALU sequencer.
// Build option: ALU_SEQ_STICKY_EN (sticky C/V flags with flag_clr).
package alu_seq_pkg;

    localparam logic [3:0] OP_SUM = 4'd0;
    localparam logic [3:0] OP_RES = 4'd1;
    localparam logic [3:0] OP_INC = 4'd2;
    localparam logic [3:0] OP_DEC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_SL  = 4'd8;
    localparam logic [3:0] OP_SR  = 4'd9;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SL) || (op == OP_SR);
    endfunction

    function automatic logic is_valid(input logic [3:0] op);
        return op <= OP_SR;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request, ALU-drive and response bundle for the ALU sequencer.
// Build option: ALU_SEQ_STICKY_EN (flag_clr stays a plain port).
interface alu_seq_if #(
    parameter int N  = 3,
    parameter int CW = 2
);
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [N-1:0]  req_a;
    logic [N-1:0]  req_b;
    logic          req_flagin;
    logic [CW-1:0] req_count;

    logic [N-1:0]  alu_a;
    logic [N-1:0]  alu_b;
    logic [3:0]    alu_select;
    logic          alu_flagin;
    logic [N-1:0]  alu_resultado;
    logic          alu_negativo;
    logic          alu_zero;
    logic          alu_cout;
    logic          alu_overflow;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [N-1:0]  rsp_result;
    logic [3:0]    rsp_flags;
    logic          rsp_err;
    logic          busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_flagin, req_count,
        output req_ready,
        output alu_a, alu_b, alu_select, alu_flagin,
        input  alu_resultado, alu_negativo, alu_zero, alu_cout,
        input  alu_overflow,
        output rsp_valid, rsp_result, rsp_flags, rsp_err, busy,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_flagin, req_count,
        input  req_ready,
        input  alu_a, alu_b, alu_select, alu_flagin,
        output alu_resultado, alu_negativo, alu_zero, alu_cout,
        output alu_overflow,
        input  rsp_valid, rsp_result, rsp_flags, rsp_err, busy,
        output rsp_ready
    );

endinterface

// File: rtl/alu_secuenciador.sv
// Sequencer in front of the combinational ALU: iterates shifts, registers results.
// Build option: ALU_SEQ_STICKY_EN adds flag_clr and sticky C/V flags.
module alu_secuenciador #(
    parameter int N  = 3,
    parameter int CW = 2
) (
    input logic clk,
    input logic rst,
`ifdef ALU_SEQ_STICKY_EN
    input logic flag_clr,
`endif
    alu_seq_if.slave bus
);
    import alu_seq_pkg::*;

    state_e        state_q;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [3:0]    op_q;
    logic          fi_q;
    logic [CW-1:0] rem_q;
    logic [N-1:0]  res_q;
    logic [3:0]    flags_q;
    logic          err_q;
    logic          vld_q;
    logic          rdy_q;
    logic          busy_q;
    logic [3:0]    alu_fl;
    logic [3:0]    keep;

    assign alu_fl = {bus.alu_negativo, bus.alu_zero,
                     bus.alu_cout, bus.alu_overflow};

`ifdef ALU_SEQ_STICKY_EN
    assign keep = {2'b00, flags_q[FLG_C], flags_q[FLG_V]};
`else
    assign keep = 4'b0000;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            fi_q    <= 1'b0;
            rem_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        a_q    <= bus.req_a;
                        b_q    <= bus.req_b;
                        op_q   <= bus.req_op;
                        fi_q   <= bus.req_flagin;
                        rem_q  <= bus.req_count;
                        rdy_q  <= 1'b0;
                        busy_q <= 1'b1;
                        unique case (1'b1)
                            !is_valid(bus.req_op): begin
                                res_q   <= '0;
                                flags_q <= keep;
                                err_q   <= 1'b1;
                                vld_q   <= 1'b1;
                                state_q <= ST_RESP;
                            end
                            is_shift(bus.req_op) && bus.req_count == '0: begin
                                res_q   <= bus.req_a;
                                flags_q <= {1'b0, bus.req_a == '0, 2'b00} | keep;
                                vld_q   <= 1'b1;
                                state_q <= ST_RESP;
                            end
                            is_shift(bus.req_op) && bus.req_count != '0: begin
                                state_q <= ST_SHIFT;
                            end
                            default: begin
                                state_q <= ST_EXEC;
                            end
                        endcase
                    end
                end
                ST_EXEC: begin
                    res_q   <= bus.alu_resultado;
                    flags_q <= alu_fl | keep;
                    vld_q   <= 1'b1;
                    state_q <= ST_RESP;
                end
                ST_SHIFT: begin
                    // Each step feeds the single-position result back as A.
                    a_q   <= bus.alu_resultado;
                    rem_q <= rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        res_q   <= bus.alu_resultado;
                        flags_q <= alu_fl | keep;
                        vld_q   <= 1'b1;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        vld_q   <= 1'b0;
                        err_q   <= 1'b0;
                        rdy_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
`ifdef ALU_SEQ_STICKY_EN
            // Clear wins over a completion setting C/V in the same cycle.
            if (flag_clr) begin
                flags_q[FLG_C] <= 1'b0;
                flags_q[FLG_V] <= 1'b0;
            end
`endif
        end
    end

    assign bus.req_ready  = rdy_q;
    assign bus.busy       = busy_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_select = op_q;
    assign bus.alu_flagin = fi_q;
    assign bus.rsp_valid  = vld_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_flags  = flags_q;
    assign bus.rsp_err    = err_q;

endmodule

// File: tb/tb_alu_secuenciador.sv
// Bench: sequencer paired with a behavioural N-bit ALU, checked against an op-level model.
// Build option: ALU_SEQ_STICKY_EN enables the sticky-flag steps.
module tb_alu_secuenciador;

    localparam int N    = 3;
    localparam int CW   = 2;
    localparam int MASK = (1 << N) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef ALU_SEQ_STICKY_EN
    logic flag_clr = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    int sticky = 0;
    logic bad_sel = 1'b0;
    logic [31:0] last_res, last_fl;

    alu_seq_if #(.N(N), .CW(CW)) bus ();

    alu_secuenciador #(.N(N), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef ALU_SEQ_STICKY_EN
        .flag_clr (flag_clr),
`endif
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    // ALU: overflow reports unsigned carry/borrow on arithmetic ops.
    logic [N:0]   alu_t;
    logic [N-1:0] alu_r;
    logic         alu_c, alu_v;

    always_comb begin
        alu_t = '0;
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (bus.alu_select)
            4'd0: alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            4'd1: alu_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            4'd2: alu_t = {1'b0, bus.alu_a} + {{N{1'b0}}, bus.alu_flagin};
            4'd3: alu_t = {1'b0, bus.alu_a} - {{N{1'b0}}, bus.alu_flagin};
            4'd6: alu_t = {1'b0, ~bus.alu_a} + {{N{1'b0}}, bus.alu_flagin};
            default: alu_t = '0;
        endcase
        case (bus.alu_select)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                alu_r = alu_t[N-1:0];
                alu_c = alu_t[N];
                alu_v = alu_t[N];
            end
            4'd4: alu_r = bus.alu_a & bus.alu_b;
            4'd5: alu_r = bus.alu_a | bus.alu_b;
            4'd6: begin
                alu_r = alu_t[N-1:0];
                alu_c = alu_t[N];
            end
            4'd7: alu_r = bus.alu_a ^ bus.alu_b;
            4'd8: begin
                alu_r = {bus.alu_a[N-2:0], 1'b0};
                alu_c = bus.alu_a[N-1];
            end
            4'd9: begin
                alu_r = {1'b0, bus.alu_a[N-1:1]};
                alu_c = bus.alu_a[0];
            end
            default: alu_r = '0;
        endcase
    end

    assign bus.alu_resultado = alu_r;
    assign bus.alu_negativo  = alu_r[N-1];
    assign bus.alu_zero      = (alu_r == '0);
    assign bus.alu_cout      = alu_c;
    assign bus.alu_overflow  = alu_v;

    always @(negedge clk)
        if (!rst && bus.busy && !bus.rsp_valid && bus.alu_select > 4'd9)
            bad_sel = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Whole-operation model: multi-position shift computed in one step.
    function automatic void model(input int op, a, b, fi, cnt,
                                  output int res, output int fl,
                                  output int err, output int lat);
        int full, c, v;
        full = 0; c = 0; v = 0; err = 0; res = 0; lat = 2;
        case (op)
            0, 1, 2, 3: begin
                case (op)
                    0: full = a + b;
                    1: full = a - b;
                    2: full = a + fi;
                    default: full = a - fi;
                endcase
                c = (full > MASK || full < 0) ? 1 : 0;
                v = c;
                res = full & MASK;
            end
            4: res = a & b;
            5: res = a | b;
            6: begin
                full = (MASK - a) + fi;
                c = (full > MASK) ? 1 : 0;
                res = full & MASK;
            end
            7: res = a ^ b;
            8, 9: begin
                lat = cnt + 1;
                if (cnt == 0) begin
                    res = a;
                end else if (op == 8) begin
                    full = a << cnt;
                    res = full & MASK;
                    c = (full >> N) & 1;
                end else begin
                    res = a >> cnt;
                    c = (a >> (cnt - 1)) & 1;
                end
            end
            default: begin
                err = 1;
                lat = 1;
            end
        endcase
        fl = (((res >> (N - 1)) & 1) << 3) | ((res == 0 ? 1 : 0) << 2)
           | (c << 1) | v;
        if ((op == 8 || op == 9) && cnt == 0) fl = (res == 0 ? 1 : 0) << 2;
        if (err == 1) fl = 0;
    endfunction

    task automatic do_op(input int op, a, b, fi, cnt, dly);
        int er, ef, ee, el, lat;
        logic [31:0] hr, hf, he;
        model(op, a, b, fi, cnt, er, ef, ee, el);
`ifdef ALU_SEQ_STICKY_EN
        ef = ef | sticky;
        sticky = ef & 3;
`endif
        @(negedge clk);
        bus.req_op     = 4'(op);
        bus.req_a      = N'(a);
        bus.req_b      = N'(b);
        bus.req_flagin = fi[0];
        bus.req_count  = CW'(cnt);
        bus.req_valid  = 1'b1;
        bus.rsp_ready  = (dly == 0);
        check("req_ready_idle", bus.req_ready, 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("latency op%0d cnt%0d", op, cnt), lat, el);
        check($sformatf("result op%0d a%0d b%0d", op, a, b),
              bus.rsp_result, er);
        check($sformatf("flags op%0d a%0d b%0d", op, a, b),
              bus.rsp_flags, ef);
        check("rsp_err", bus.rsp_err, ee);
        check("req_ready_resp", bus.req_ready, 0);
        check("busy_resp", bus.busy, 1);
        hr = bus.rsp_result;
        hf = bus.rsp_flags;
        he = bus.rsp_err;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_op    = 4'($urandom_range(0, 15));
            bus.req_a     = N'($urandom);
            bus.req_count = CW'($urandom);
            @(posedge clk);
            #1;
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_result", bus.rsp_result, hr);
            check("hold_flags", bus.rsp_flags, hf);
            check("hold_err", bus.rsp_err, he);
            check("hold_ready", bus.req_ready, 0);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rsp_done", bus.rsp_valid, 0);
        check("ready_back", bus.req_ready, 1);
        check("busy_idle", bus.busy, 0);
        check("err_cleared", bus.rsp_err, 0);
        last_res = hr;
        last_fl  = hf;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 1);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_result"}, bus.rsp_result, 0);
        check({tag, "_flags"}, bus.rsp_flags, 0);
        check({tag, "_err"}, bus.rsp_err, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_alu"}, {bus.alu_a, bus.alu_b, bus.alu_select,
                              bus.alu_flagin}, 0);
    endtask

`ifdef ALU_SEQ_STICKY_EN
    task automatic pulse_clr();
        @(negedge clk);
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        sticky = 0;
    endtask
`endif

    initial begin
        int op;
        logic seen;
        bus.req_valid  = 1'b0;
        bus.req_op     = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_flagin = 1'b0;
        bus.req_count  = '0;
        bus.rsp_ready  = 1'b1;
        #12;
        check_reset("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset("post_reset");

        do_op(0, 3, 6, 0, 0, 0);
        check("plan_add_result", last_res, 1);
        check("plan_add_flags", last_fl, 4'b0011);

        do_op(8, 3, 0, 0, 2, 0);
        check("plan_sl_result", last_res, 3'b100);

        do_op(12, 5, 2, 0, 1, 0);
        check("plan_bad_sel", bad_sel, 0);

        do_op(1, 2, 5, 0, 0, 5);
        do_op(9, 6, 0, 0, 0, 0);
        do_op(9, 0, 0, 0, 0, 1);
        do_op(6, 5, 0, 1, 0, 0);
        do_op(8, 7, 0, 0, 3, 2);

        // Reset in the second SHIFT cycle drops the op without a response.
        @(negedge clk);
        bus.req_op    = 4'd9;
        bus.req_a     = 3'd7;
        bus.req_count = 2'd3;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset("mid_rst");
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            seen = seen | bus.rsp_valid;
        end
        @(negedge clk);
        rst = 1'b0;
        sticky = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            seen = seen | bus.rsp_valid;
        end
        check("mid_rst_no_rsp", seen, 0);
        check("mid_rst_ready", bus.req_ready, 1);

`ifdef ALU_SEQ_STICKY_EN
        pulse_clr();
        do_op(0, 3, 6, 0, 0, 0);
        do_op(4, 1, 1, 0, 0, 0);
        check("sticky_c_kept", last_fl[1], 1);
        pulse_clr();
        do_op(4, 1, 1, 0, 0, 0);
        check("sticky_c_cleared", last_fl[1], 0);
`endif

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 4) == 0) op = $urandom_range(10, 15);
            else op = $urandom_range(0, 9);
            do_op(op, $urandom_range(0, MASK), $urandom_range(0, MASK),
                  $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 3));
        end
        check("never_bad_sel", bad_sel, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
